// File: rtl/led_matrix_scan_pwm.sv
// led_matrix_scan_pwm: row-multiplexed LED matrix driver with inter-row blanking,
// global PWM dimming and a double-buffered frame that swaps only at frame boundaries.
module led_matrix_scan_pwm #(
    parameter int ROWS           = 8,
    parameter int COLS           = 8,
    parameter int SCAN_DIV       = 5000,
    parameter int BLANK          = 16,
    parameter int BRIGHT_W       = 3,
    parameter int ROW_ACTIVE_LOW = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [BRIGHT_W-1:0]  brightness,
    input  logic [ROWS*COLS-1:0] frame_in,
    input  logic                 load,
    output logic                 pending,
    output logic                 frame_start,
    output logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(ROWS);
    localparam logic [ROWS-1:0] IDLE = {ROWS{ROW_ACTIVE_LOW != 0}};

    logic [CW-1:0]        cnt, cnt_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [ROWS*COLS-1:0] staging, display;
    logic                 slot_end, last_row, boundary, transfer, lit;
    logic [ROWS-1:0]      row_nx;
    logic [COLS-1:0]      col_nx;

    always_comb begin
        slot_end = cnt == CW'(SCAN_DIV - 1);
        last_row = idx == IW'(ROWS - 1);
        boundary = enable && slot_end && last_row;
        // a coincident load defers the swap so the newest frame is never torn
        transfer = pending && !load && (boundary || !enable);
        cnt_nx   = (!enable || slot_end) ? '0 : cnt + 1'b1;
        idx_nx   = !enable ? '0 : !slot_end ? idx : last_row ? '0 : idx + 1'b1;
        lit      = enable && cnt >= CW'(BLANK) && BRIGHT_W'(cnt) <= brightness;
        row_nx   = lit ? IDLE ^ (ROWS'(1) << idx) : IDLE;
        col_nx   = lit ? display[idx*COLS +: COLS] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            staging     <= '0;
            display     <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            row         <= IDLE;
            col         <= '0;
        end else begin
            cnt         <= cnt_nx;
            idx         <= idx_nx;
            row         <= row_nx;
            col         <= col_nx;
            frame_start <= transfer;
            if (load) begin
                staging <= frame_in;
                pending <= 1'b1;
            end else if (transfer) begin
                display <= staging;
                pending <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_scan_pwm.sv
// tb_led_matrix_scan_pwm: directed scan/PWM/load scenarios on a 4x4 matrix, with
// hand-computed output expectations queued per cycle and checked by a monitor.
module tb_led_matrix_scan_pwm;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [1:0]  brightness = 2'd3;
    logic [15:0] frame_in = '0;
    logic        load = 1'b0;
    logic        pending, frame_start;
    logic [3:0]  row, col;

    led_matrix_scan_pwm #(
        .ROWS(4), .COLS(4), .SCAN_DIV(16), .BLANK(4), .BRIGHT_W(2), .ROW_ACTIVE_LOW(1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .brightness(brightness),
        .frame_in(frame_in), .load(load), .pending(pending), .frame_start(frame_start),
        .row(row), .col(col)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         tag;
        int         cyc;
        logic [3:0] row;
        logic [3:0] col;
        logic       pend;
        logic       fs;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc;
    int   checks = 0;
    int   failures = 0;

    // cyc == number of rising edges since the last reset release
    always @(posedge clock or posedge reset)
        if (reset) cyc <= 0;
        else cyc <= cyc + 1;

    always @(negedge clock) begin
        if (!reset) begin
            while (q.size() != 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc || {row, col, pending, frame_start} !== {e.row, e.col, e.pend, e.fs}) begin
                    failures++;
                    $display("FAIL t%0d cyc=%0d (at %0d) row/col/pend/fs got %b/%h/%b/%b want %b/%h/%b/%b",
                             e.tag, e.cyc, cyc, row, col, pending, frame_start, e.row, e.col, e.pend, e.fs);
                end
            end
        end
    end

    task automatic ex(input int tag, input int c, input logic [3:0] r, input logic [3:0] cl,
                      input logic p, input logic f);
        q.push_back('{tag: tag, cyc: c, row: r, col: cl, pend: p, fs: f});
    endtask

    task automatic go_to(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic chk_reset(input string name);
        checks++;
        if ({row, col, pending, frame_start} !== {4'b1111, 4'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL %s row/col/pend/fs got %b/%h/%b/%b want 1111/0/0/0",
                     name, row, col, pending, frame_start);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clock);
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain %0d expectations never reached, want 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk_reset("reset_state");
        // scan order, blanking and first frame transfer at the first boundary
        ex(1, 1, 4'b1111, 4'h0, 1, 0);
        ex(1, 63, 4'b0111, 4'h0, 1, 0);
        ex(1, 64, 4'b0111, 4'h0, 0, 1);
        ex(1, 65, 4'b1111, 4'h0, 0, 0);
        ex(1, 68, 4'b1111, 4'h0, 0, 0);
        ex(1, 69, 4'b1110, 4'h1, 0, 0);
        ex(1, 80, 4'b1110, 4'h1, 0, 0);
        ex(1, 81, 4'b1111, 4'h0, 0, 0);
        ex(1, 85, 4'b1101, 4'h2, 0, 0);
        ex(1, 101, 4'b1011, 4'h4, 0, 0);
        ex(1, 117, 4'b0111, 4'h8, 0, 0);
        ex(1, 128, 4'b0111, 4'h8, 0, 0);
        reset = 1'b0;
        frame_in = 16'h8421;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(128);
        // brightness 1 then 0: 2-on/2-off and 1-on/3-off windows
        ex(2, 133, 4'b1110, 4'h1, 0, 0);
        ex(2, 134, 4'b1110, 4'h1, 0, 0);
        ex(2, 135, 4'b1111, 4'h0, 0, 0);
        ex(2, 136, 4'b1111, 4'h0, 0, 0);
        ex(2, 137, 4'b1110, 4'h1, 0, 0);
        ex(2, 144, 4'b1111, 4'h0, 0, 0);
        ex(2, 149, 4'b1101, 4'h2, 0, 0);
        ex(2, 150, 4'b1111, 4'h0, 0, 0);
        ex(2, 153, 4'b1101, 4'h2, 0, 0);
        ex(2, 154, 4'b1111, 4'h0, 0, 0);
        brightness = 2'd1;
        go_to(144);
        brightness = 2'd0;
        go_to(160);
        brightness = 2'd3;
        // two loads inside one frame: last wins, single frame_start
        ex(3, 171, 4'b1011, 4'h4, 1, 0);
        ex(3, 191, 4'b0111, 4'h8, 1, 0);
        ex(3, 192, 4'b0111, 4'h8, 0, 1);
        ex(3, 193, 4'b1111, 4'h0, 0, 0);
        ex(3, 197, 4'b1110, 4'hF, 0, 0);
        ex(3, 213, 4'b1101, 4'hF, 0, 0);
        go_to(170);
        frame_in = 16'h1111;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(180);
        frame_in = 16'hFFFF;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(230);
        // load on the boundary defers the swap by a whole frame
        ex(4, 245, 4'b0111, 4'hF, 1, 0);
        ex(4, 256, 4'b0111, 4'hF, 1, 0);
        ex(4, 261, 4'b1110, 4'hF, 1, 0);
        ex(4, 309, 4'b0111, 4'hF, 1, 0);
        ex(4, 319, 4'b0111, 4'hF, 1, 0);
        ex(4, 320, 4'b0111, 4'hF, 0, 1);
        ex(4, 325, 4'b1110, 4'hA, 0, 0);
        go_to(240);
        frame_in = 16'h5555;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(255);
        frame_in = 16'hAAAA;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(326);
        // disable with a pending frame: immediate dark + transfer, restart at row 0
        ex(6, 331, 4'b1110, 4'hA, 1, 0);
        ex(6, 333, 4'b1110, 4'hA, 1, 0);
        ex(6, 341, 4'b1111, 4'h0, 0, 1);
        ex(6, 342, 4'b1111, 4'h0, 0, 0);
        ex(6, 344, 4'b1111, 4'h0, 0, 0);
        ex(6, 349, 4'b1111, 4'h0, 0, 0);
        ex(6, 350, 4'b1110, 4'h8, 0, 0);
        ex(6, 366, 4'b1101, 4'h4, 0, 0);
        go_to(330);
        frame_in = 16'h1248;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        go_to(340);
        enable = 1'b0;
        go_to(345);
        enable = 1'b1;
        go_to(385);
        drain();
        // asynchronous reset mid-slot of row 2
        #2 reset = 1'b1;
        #1 chk_reset("async_reset");
        ex(5, 1, 4'b1111, 4'h0, 0, 0);
        ex(5, 4, 4'b1111, 4'h0, 0, 0);
        ex(5, 5, 4'b1110, 4'h0, 0, 0);
        ex(5, 21, 4'b1101, 4'h0, 0, 0);
        ex(5, 64, 4'b0111, 4'h0, 0, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
